// File: rtl/icache_dm_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_dm_pkg;

  localparam int ICACHE_LINES    = 16;
  localparam int ICACHE_BEATS    = 4;
  localparam int ICACHE_OFFSET_W = 5;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef enum logic [2:0] {
    IDLE,
    HIT_RESP,
    MISS_REQ,
    REFILL,
    UNC_REQ,
    RESP
  } icache_state_t;

endpackage

// File: rtl/icache_data_ram.sv
// Line data storage: one write port, combinational read, addressed by (index, beat).
module icache_data_ram #(
  parameter int LINES = 16,
  parameter int BEATS = 4,
  localparam int IDX_W  = $clog2(LINES),
  localparam int BEAT_W = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  w_index,
  input  logic [BEAT_W-1:0] w_beat,
  input  logic [63:0]       w_data,
  input  logic [IDX_W-1:0]  r_index,
  input  logic [BEAT_W-1:0] r_beat,
  output logic [63:0]       r_data
);

  logic [63:0] mem [LINES*BEATS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[{w_index, w_beat}] <= w_data;
    end
  end

  assign r_data = mem[{r_index, r_beat}];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with uncached bypass, fence.i flush
// and saturating hit/miss counters.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int LINES = ICACHE_LINES,
  parameter int BEATS = ICACHE_BEATS,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  ibus_req_t        ireq,
  output ibus_resp_t       iresp,
  input  logic             flush,
  output logic             mreq_valid,
  output logic [63:0]      mreq_addr,
  output logic [7:0]       mreq_len,
  input  logic             mresp_ready,
  input  logic             mresp_last,
  input  logic [63:0]      mresp_data,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam int OFF_W  = BEAT_W + 3;
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = 64 - OFF_W - IDX_W;

  icache_state_t     state;
  logic [63:0]       addr_q;
  logic [BEAT_W-1:0] beat_cnt;
  logic              data_ok_q;
  logic [31:0]       data_q;
  logic              flush_pend;
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_mem [LINES];

  logic [IDX_W-1:0]  req_idx;
  logic [BEAT_W-1:0] req_beat;
  logic [TAG_W-1:0]  req_tag;
  logic              req_cached;
  logic [IDX_W-1:0]  q_idx;
  logic [BEAT_W-1:0] q_beat;
  logic [TAG_W-1:0]  q_tag;
  logic [63:0]       ram_rdata;
  logic [31:0]       rd_word;
  logic [31:0]       beat_word;
  logic              in_refill;
  logic              ram_we;
  logic              install;
  logic              is_hit;
  logic              clear_all;
  logic              unused_addr_bits;

  assign req_idx    = ireq.addr[OFF_W+IDX_W-1:OFF_W];
  assign req_beat   = ireq.addr[OFF_W-1:3];
  assign req_tag    = ireq.addr[63:OFF_W+IDX_W];
  assign req_cached = ireq.addr[31];
  assign q_idx      = addr_q[OFF_W+IDX_W-1:OFF_W];
  assign q_beat     = addr_q[OFF_W-1:3];
  assign q_tag      = addr_q[63:OFF_W+IDX_W];

  assign unused_addr_bits = ^{ireq.addr[1:0], addr_q[1:0]};

  assign rd_word   = ireq.addr[2] ? ram_rdata[63:32] : ram_rdata[31:0];
  assign beat_word = addr_q[2] ? mresp_data[63:32] : mresp_data[31:0];

  assign in_refill = (state == MISS_REQ) || (state == REFILL);
  assign ram_we    = in_refill && mresp_ready;
  assign install   = ram_we && mresp_last;

  // A flush in the same IDLE cycle as a request forces that request to miss.
  assign is_hit = req_cached && valid_q[req_idx] && (tag_mem[req_idx] == req_tag) && !flush;

  // Deferred flushes land on the transition back to IDLE, after any install.
  assign clear_all = ((state == IDLE) && flush) ||
                     (((state == HIT_RESP) || (state == RESP)) && (flush_pend || flush));

  always_comb begin
    iresp.addr_ok = (state == IDLE) && ireq.valid && !reset;
    iresp.data_ok = data_ok_q;
    iresp.data    = data_q;
  end

  icache_data_ram #(
    .LINES(LINES),
    .BEATS(BEATS)
  ) u_data_ram (
    .clk    (clk),
    .we     (ram_we),
    .w_index(q_idx),
    .w_beat (beat_cnt),
    .w_data (mresp_data),
    .r_index(req_idx),
    .r_beat (req_beat),
    .r_data (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
    end else if (install) begin
      valid_q[q_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (install) begin
      tag_mem[q_idx] <= q_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      beat_cnt   <= '0;
      data_ok_q  <= 1'b0;
      data_q     <= '0;
      flush_pend <= 1'b0;
      mreq_valid <= 1'b0;
      mreq_addr  <= '0;
      mreq_len   <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      data_ok_q <= 1'b0;
      if ((state != IDLE) && flush) begin
        flush_pend <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (ireq.valid) begin
            addr_q <= ireq.addr;
            if (!req_cached) begin
              state      <= UNC_REQ;
              mreq_valid <= 1'b1;
              mreq_addr  <= {ireq.addr[63:3], 3'b000};
              mreq_len   <= 8'd0;
            end else if (is_hit) begin
              state     <= HIT_RESP;
              data_q    <= rd_word;
              data_ok_q <= 1'b1;
              if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
            end else begin
              state      <= MISS_REQ;
              beat_cnt   <= '0;
              mreq_valid <= 1'b1;
              mreq_addr  <= {ireq.addr[63:OFF_W], {OFF_W{1'b0}}};
              mreq_len   <= 8'(BEATS - 1);
              if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
            end
          end
        end
        MISS_REQ, REFILL: begin
          if (mresp_ready) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == q_beat) data_q <= beat_word;
            if (mresp_last) begin
              mreq_valid <= 1'b0;
              data_ok_q  <= 1'b1;
              state      <= RESP;
            end else begin
              state <= REFILL;
            end
          end
        end
        UNC_REQ: begin
          if (mresp_ready) begin
            data_q <= beat_word;
            if (mresp_last) begin
              mreq_valid <= 1'b0;
              data_ok_q  <= 1'b1;
              state      <= RESP;
            end
          end
        end
        HIT_RESP, RESP: begin
          state      <= IDLE;
          flush_pend <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
